inst_fetch_stage: RTL
=====================

// Module: inst_fetch_stage
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline register of the MIPS pipeline.
//  - Owns the PC and fetches from instruction memory over a req/ack handshake.
//  - Presents Inst, PC and PC+4 to the decode stage (the control unit and the register file).
//  - Honours the hazard-unit stall and the EX-stage branch/jump redirect.
//  - Flushed slots carry 32'h0000_0000, which decode treats as NOP.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
// PORTS
//  clk           in   1   clock, all state updates on rising edge
//  rst_n         in   1   asynchronous active-low reset
//  imem_req      out  1   fetch request to instruction memory
//  imem_addr     out  32  fetch byte address (word aligned)
//  imem_ack      in   1   memory ack; imem_rdata valid in same cycle
//  imem_rdata    in   32  fetched instruction word
//  stall         in   1   ID cannot accept; hold IF/ID and PC
//  redirect      in   1   branch/jump taken; flush and refetch
//  redirect_pc   in   32  target PC, sampled when redirect=1
//  inst_out      out  32  IF/ID instruction to decode
//  pc_out        out  32  IF/ID PC of inst_out
//  pc_plus4_out  out  32  IF/ID pc_out+4 (jal link, branch base)
//  inst_valid    out  1   IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - pc=RESET_PC; state=IDLE; imem_req=0.
//  - inst_out=0, pc_out=0, pc_plus4_out=0, inst_valid=0.
//  States:
//  - IDLE: imem_req=0; unconditionally goes to REQ in the next cycle.
//  - REQ: imem_req=1, imem_addr=pc. Outcomes in priority order:
//    redirect -> if ack: pc<=redirect_pc, stay REQ.
//                if !ack: pend_pc<=redirect_pc, go DROP.
//    ack & !stall -> IF/ID<=rdata/pc/pc+4, valid=1; pc<=pc+4; stay REQ.
//    ack & stall  -> buf<=rdata, go HOLD.
//    !ack         -> stay REQ; address held.
//  - HOLD: imem_req=0. Outcomes:
//    redirect -> drop buf; pc<=redirect_pc; go REQ.
//    !stall   -> IF/ID<=buf/pc/pc+4; pc<=pc+4; go REQ.
//    stall    -> stay HOLD.
//  - DROP: imem_req=1, imem_addr=old pc; wait for ack and discard the data.
//    On ack: pc<=pend_pc; go REQ.
//    A new redirect while in DROP overwrites pend_pc; the last redirect wins.
//  Handshake rules:
//  - While imem_req=1 and no ack, imem_addr is stable.
//  - imem_req is never withdrawn before ack.
//  IF/ID register update, priority order:
//  1. redirect=1: inst_out=0, inst_valid=0; pc_out and pc_plus4_out are don't-care.
//  2. stall=1: hold all IF/ID outputs.
//  3. Instruction accepted this cycle: load it.
//  4. Otherwise: bubble (inst_out=0, inst_valid=0).
//  Timing and arithmetic:
//  - Latency: ack in cycle N -> inst_out valid in cycle N+1.
//  - Zero-wait memory (ack with req) gives 1 instruction/cycle throughput.
//  - PC arithmetic is mod 2^32: 32'hFFFF_FFFC+4 = 0, no error flag.
//  - redirect_pc[1:0] is forced to 2'b00.
//  - redirect+stall in the same cycle: redirect wins, and IF/ID is flushed.
//  - Reset asserted mid-request: the outstanding ack after reset is ignored,
//    because IDLE does not sample ack.
// TESTING
//  1. Reset, ack tied high -> IDLE for 1 cycle, then addr 0,4,8,C on consecutive
//     cycles; inst_out follows 1 cycle later with valid=1.
//  2. ack delayed 3 cycles at addr 8 -> imem_addr stays 8 for 4 cycles; 3 bubbles
//     (inst_out=0, valid=0); pc_out=8, pc_plus4_out=C on load.
//  3. stall asserted 2 cycles as word @0x10 is acked -> IF/ID held; buffered word
//     appears when stall drops; no refetch of 0x10; next addr 0x14.
//  4. redirect to 0x40 while REQ@0x20 is unacked -> DROP until ack, data discarded;
//     next req addr 0x40; IF/ID shows NOP with valid=0.
//  5. redirect and stall in the same cycle during HOLD -> flush; buffer dropped;
//     fetch resumes at redirect_pc.
//  6. pc=0xFFFF_FFFC with ack -> next addr 0x0000_0000; rst_n pulsed mid-wait ->
//     all outputs 0, restart from RESET_PC.

Source files
------------

// File: rtl/inst_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the MIPS pipeline.
// Fetches over a req/ack handshake, honours stall and EX-stage redirect, flushes to NOP.
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic        inst_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      state_r;
  logic        req_r;
  logic [31:0] pc_r;
  logic [31:0] pend_pc_r;
  logic [31:0] buf_r;
  logic [31:0] inst_r;
  logic [31:0] pc_out_r;
  logic [31:0] pc_plus4_r;
  logic        valid_r;

  logic [31:0] target_s;
  logic [31:0] pc_next4_s;
  logic        accept_s;
  logic [31:0] word_s;

  assign target_s   = {redirect_pc[31:2], 2'b00};
  assign pc_next4_s = pc_r + 32'd4;

  // Decide whether a word enters IF/ID this cycle and where it comes from.
  always_comb begin
    accept_s = 1'b0;
    word_s   = imem_rdata;
    case (state_r)
      REQ: begin
        accept_s = imem_ack & ~redirect & ~stall;
        word_s   = imem_rdata;
      end
      HOLD: begin
        accept_s = ~redirect & ~stall;
        word_s   = buf_r;
      end
      default: begin
        accept_s = 1'b0;
        word_s   = imem_rdata;
      end
    endcase
  end

  // Fetch FSM: PC, pending redirect target, stall buffer and request flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      req_r     <= 1'b0;
      pc_r      <= RESET_PC;
      pend_pc_r <= 32'h0000_0000;
      buf_r     <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= REQ;
          req_r   <= 1'b1;
          if (redirect) pc_r <= target_s;
        end
        REQ: begin
          if (redirect) begin
            if (imem_ack) begin
              pc_r <= target_s;
            end else begin
              pend_pc_r <= target_s;
              state_r   <= DROP;
            end
          end else if (imem_ack) begin
            if (stall) begin
              buf_r   <= imem_rdata;
              state_r <= HOLD;
              req_r   <= 1'b0;
            end else begin
              pc_r <= pc_next4_s;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_r    <= target_s;
            state_r <= REQ;
            req_r   <= 1'b1;
          end else if (!stall) begin
            pc_r    <= pc_next4_s;
            state_r <= REQ;
            req_r   <= 1'b1;
          end
        end
        DROP: begin
          // The stale fetch must complete before the new target is requested.
          if (imem_ack) begin
            pc_r    <= redirect ? target_s : pend_pc_r;
            state_r <= REQ;
          end else if (redirect) begin
            pend_pc_r <= target_s;
          end
        end
        default: begin
          state_r <= IDLE;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID pipeline register: flush beats stall, stall beats load, else bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_r     <= 32'h0000_0000;
      pc_out_r   <= 32'h0000_0000;
      pc_plus4_r <= 32'h0000_0000;
      valid_r    <= 1'b0;
    end else if (redirect) begin
      inst_r  <= 32'h0000_0000;
      valid_r <= 1'b0;
    end else if (!stall) begin
      if (accept_s) begin
        inst_r     <= word_s;
        pc_out_r   <= pc_r;
        pc_plus4_r <= pc_next4_s;
        valid_r    <= 1'b1;
      end else begin
        inst_r  <= 32'h0000_0000;
        valid_r <= 1'b0;
      end
    end
  end

  assign imem_req     = req_r;
  assign imem_addr    = pc_r;
  assign inst_out     = inst_r;
  assign pc_out       = pc_out_r;
  assign pc_plus4_out = pc_plus4_r;
  assign inst_valid   = valid_r;

endmodule
